cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Instruction-cycle control sequencer for the 8-bit RISC CPU. It consumes the `fetch` strobe produced by the CPU clock generator and runs an 8-phase instruction cycle locked to it. In each phase it decodes the current opcode and the accumulator-zero flag into registered control strobes for the PC, IR, accumulator, memory and data-bus driver. It sits between the clock generator and the datapath.

## Interface
Parameters:
- `START_ON_RESET`, default 0: 1 = leave IDLE at the first clock after reset without waiting for a `fetch` rise.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch` in 1: phase strobe from the clock generator. It changes on the falling edge of `clk`, is high for 4 clocks and low for 4 clocks, with an 8-clock period.
- `opcode` in 3: instruction register opcode field. It is valid from S2 onward.
- `zero` in 1: accumulator-zero flag.
- `inc_pc` out 1: increment PC.
- `load_ir` out 1: load the instruction register byte.
- `rd` out 1: memory read.
- `wr` out 1: memory write.
- `load_acc` out 1: load the accumulator from the ALU.
- `load_pc` out 1: load PC from the IR address field.
- `datactl_ena` out 1: drive the accumulator onto the data bus.
- `halt` out 1: CPU halted (sticky).
- `phase` out 3: current phase index 0..7. It reads 0 in IDLE and HALTED.
- `running` out 1: 1 while in S0..S7.
- `sync_err` out 1: sticky fetch-misalignment flag.

## Operation
- States: IDLE, S0..S7, HALTED. The state and all outputs are registered. The outputs shown in a state are those driven during the clock in which the state register holds that state.
- `fetch_q` holds the value of `fetch` sampled at the previous edge. `rise = fetch & ~fetch_q`.
- Transitions:
  - IDLE→S0 on an edge with `rise=1`, or at the first edge after reset if `START_ON_RESET=1`.
  - Sk→Sk+1 for k<7.
  - S7→S0.
  - S3→HALTED when `opcode=000`.
  - HALTED is left only by `rst`.
- Opcode classes:
  - HLT=000, SKZ=001, JMP=111, STO=110.
  - ALU class: ADD=010, AND=011, XOR=100, LDA=101.
- Strobes by phase (any strobe not listed is 0):
  - S0: `load_ir`, `rd`, `inc_pc`.
  - S1: `load_ir`, `rd`, `inc_pc`.
  - S2: none.
  - S3: none. If HLT, the next state is HALTED.
  - S4: ALU class gives `rd`. JMP gives `load_pc`. STO gives `datactl_ena`.
  - S5: ALU class gives `rd` and `load_acc`. SKZ with `zero=1` gives `inc_pc`. JMP gives `load_pc` and `inc_pc`. STO gives `datactl_ena` and `wr`.
  - S6: STO gives `datactl_ena`.
  - S7: SKZ with `zero=1` gives `inc_pc`.
- `opcode` and `zero` are sampled at the edge that enters the phase. Changes within a phase have no effect until the next edge.
- In HALTED: `halt=1`, all strobes are 0, `running=0`, and `fetch` is ignored.
- `wr` and `rd` are never high together. `load_pc` and `load_acc` are never high together.

## Timing
- Reset values: all strobes 0, `halt`=0, `phase`=0, `running`=0, `sync_err`=0, `fetch_q`=0. The state goes to IDLE.
- Reset mid-cycle aborts the cycle. Outputs take their reset values at the same edge that samples `rst=1`.
- First `fetch` rise: with `fetch` going high between edges N-1 and N, `rise` is seen at edge N. S0 and its strobes are active in the clock after edge N.
- In steady state, the next `rise` coincides with the S7→S0 edge, so the cycle period is exactly 8 clocks.
- `halt` rises at the edge that leaves S3, which is 4 clocks after S0 is entered.
- A `rise` and an S3 HLT decode at the same edge: HALTED wins.

## Configuration
- `CTRL_SYNC_CHECK_EN` defined:
  - A `rise` seen in S0..S6 sets `sync_err` to 1 and forces the next state to S0 (resync).
  - Reaching S7 with no `rise` at its exit edge also sets `sync_err`, and the state still proceeds to S0.
  - `sync_err` clears only on `rst`.
- Not defined: `sync_err` is tied to 0, `fetch` is used only to leave IDLE, and the sequencer free-runs.

## Test plan
- Reset, then a `fetch` waveform of 4 high / 4 low with `opcode=010` (ADD): `load_ir`/`rd`/`inc_pc` high in S0 and S1, `rd` in S4, `rd` and `load_acc` in S5; period 8; `sync_err=0`.
- `opcode=111` (JMP): `load_pc` in S4 and S5, `inc_pc` also in S5; no `rd`/`wr` after S1.
- `opcode=001` (SKZ) with `zero=1`: `inc_pc` in S5 and S7. Repeat with `zero=0`: no `inc_pc` after S1.
- `opcode=110` (STO): `datactl_ena` in S4–S6, `wr` only in S5; `rd` never high while `wr`=1.
- `opcode=000` (HLT): `halt=1` from S3+1 onward and all strobes 0 for 20 more clocks. Then `rst` for 1 clock: outputs return to reset values and the controller waits in IDLE.
- With `CTRL_SYNC_CHECK_EN`, shift `fetch` by 3 clocks mid-run: `sync_err` goes to 1, `phase` restarts at 0 at the misaligned rise, and it is clean thereafter.

Source files
------------

// File: rtl/cpu_ctrl_seq.sv
// Instruction-cycle control sequencer: 8-phase cycle locked to the fetch strobe, registered control strobes.
// Optional fetch alignment checking is enabled by defining CTRL_SYNC_CHECK_EN.
module cpu_ctrl_seq #(
    parameter bit START_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_ir,
    output logic       rd,
    output logic       wr,
    output logic       load_acc,
    output logic       load_pc,
    output logic       datactl_ena,
    output logic       halt,
    output logic [2:0] phase,
    output logic       running,
    output logic       sync_err
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [3:0] {
        IDLE, S0, S1, S2, S3, S4, S5, S6, S7, HALTED
    } state_t;

    state_t     state_reg, state_next;
    logic       fetch_q_reg;
    logic       rise;
    logic       inc_pc_reg, inc_pc_next;
    logic       load_ir_reg, load_ir_next;
    logic       rd_reg, rd_next;
    logic       wr_reg, wr_next;
    logic       load_acc_reg, load_acc_next;
    logic       load_pc_reg, load_pc_next;
    logic       datactl_ena_reg, datactl_ena_next;
    logic       halt_reg, halt_next;
    logic [2:0] phase_reg, phase_next;
    logic       running_reg, running_next;
    logic       is_alu, is_skz, is_jmp, is_sto;

`ifdef CTRL_SYNC_CHECK_EN
    logic       sync_err_reg, sync_err_next;
`endif

    assign rise   = fetch & ~fetch_q_reg;
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_skz = (opcode == OP_SKZ);
    assign is_jmp = (opcode == OP_JMP);
    assign is_sto = (opcode == OP_STO);

    // Next-state: HLT at the S3 exit beats a coincident resync rise.
    always_comb begin
        state_next = state_reg;
`ifdef CTRL_SYNC_CHECK_EN
        sync_err_next = sync_err_reg;
`endif
        case (state_reg)
            IDLE:   if (rise || START_ON_RESET) state_next = S0;
            S0:     state_next = S1;
            S1:     state_next = S2;
            S2:     state_next = S3;
            S3:     state_next = (opcode == OP_HLT) ? HALTED : S4;
            S4:     state_next = S5;
            S5:     state_next = S6;
            S6:     state_next = S7;
            S7:     state_next = S0;
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
`ifdef CTRL_SYNC_CHECK_EN
        if (state_reg == S7 && !rise) begin
            sync_err_next = 1'b1;
        end else if (rise && state_next != HALTED &&
                     state_reg != IDLE && state_reg != HALTED && state_reg != S7) begin
            state_next    = S0;
            sync_err_next = 1'b1;
        end
`endif
    end

    // Strobes belong to the state being entered, decoded from inputs at that edge.
    always_comb begin
        inc_pc_next      = 1'b0;
        load_ir_next     = 1'b0;
        rd_next          = 1'b0;
        wr_next          = 1'b0;
        load_acc_next    = 1'b0;
        load_pc_next     = 1'b0;
        datactl_ena_next = 1'b0;
        halt_next        = 1'b0;
        phase_next       = 3'd0;
        running_next     = 1'b1;
        case (state_next)
            S0: begin
                phase_next   = 3'd0;
                load_ir_next = 1'b1;
                rd_next      = 1'b1;
                inc_pc_next  = 1'b1;
            end
            S1: begin
                phase_next   = 3'd1;
                load_ir_next = 1'b1;
                rd_next      = 1'b1;
                inc_pc_next  = 1'b1;
            end
            S2: phase_next = 3'd2;
            S3: phase_next = 3'd3;
            S4: begin
                phase_next       = 3'd4;
                rd_next          = is_alu;
                load_pc_next     = is_jmp;
                datactl_ena_next = is_sto;
            end
            S5: begin
                phase_next       = 3'd5;
                rd_next          = is_alu;
                load_acc_next    = is_alu;
                inc_pc_next      = (is_skz && zero) || is_jmp;
                load_pc_next     = is_jmp;
                datactl_ena_next = is_sto;
                wr_next          = is_sto;
            end
            S6: begin
                phase_next       = 3'd6;
                datactl_ena_next = is_sto;
            end
            S7: begin
                phase_next  = 3'd7;
                inc_pc_next = is_skz && zero;
            end
            HALTED: begin
                halt_next    = 1'b1;
                running_next = 1'b0;
            end
            default: running_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            fetch_q_reg     <= 1'b0;
            inc_pc_reg      <= 1'b0;
            load_ir_reg     <= 1'b0;
            rd_reg          <= 1'b0;
            wr_reg          <= 1'b0;
            load_acc_reg    <= 1'b0;
            load_pc_reg     <= 1'b0;
            datactl_ena_reg <= 1'b0;
            halt_reg        <= 1'b0;
            phase_reg       <= 3'd0;
            running_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fetch_q_reg     <= fetch;
            inc_pc_reg      <= inc_pc_next;
            load_ir_reg     <= load_ir_next;
            rd_reg          <= rd_next;
            wr_reg          <= wr_next;
            load_acc_reg    <= load_acc_next;
            load_pc_reg     <= load_pc_next;
            datactl_ena_reg <= datactl_ena_next;
            halt_reg        <= halt_next;
            phase_reg       <= phase_next;
            running_reg     <= running_next;
        end
    end

`ifdef CTRL_SYNC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_reg <= 1'b0;
        end else begin
            sync_err_reg <= sync_err_next;
        end
    end
    assign sync_err = sync_err_reg;
`else
    assign sync_err = 1'b0;
`endif

    assign inc_pc      = inc_pc_reg;
    assign load_ir     = load_ir_reg;
    assign rd          = rd_reg;
    assign wr          = wr_reg;
    assign load_acc    = load_acc_reg;
    assign load_pc     = load_pc_reg;
    assign datactl_ena = datactl_ena_reg;
    assign halt        = halt_reg;
    assign phase       = phase_reg;
    assign running     = running_reg;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: a cycle-level reference model predicts every clock's outputs,
// a separate monitor compares them; honours CTRL_SYNC_CHECK_EN the same way the design does.
module tb_cpu_ctrl_seq;

    localparam bit START_ON_RESET = 1'b0;
    localparam int POS_IDLE = -1;
    localparam int POS_HALT = 8;

    logic       clk = 1'b0;
    logic       rst, fetch, zero;
    logic [2:0] opcode;
    logic       inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena;
    logic       halt, running, sync_err;
    logic [2:0] phase;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [12:0] exp_q[$];
    logic [2:0]  op_queue[$];
    int          fcnt     = 0;
    bit          fetch_on = 1'b0;
    bit          rand_op  = 1'b0;

    cpu_ctrl_seq #(.START_ON_RESET(START_ON_RESET)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .opcode(opcode), .zero(zero),
        .inc_pc(inc_pc), .load_ir(load_ir), .rd(rd), .wr(wr), .load_acc(load_acc),
        .load_pc(load_pc), .datactl_ena(datactl_ena), .halt(halt), .phase(phase),
        .running(running), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Vector order: inc_pc load_ir rd wr load_acc load_pc datactl_ena halt phase[2:0] running sync_err
    function automatic logic [12:0] expect_for(input int pos, input logic [2:0] op,
                                               input logic z, input bit s);
        bit alu, jmp, sto, skz;
        bit inc, ir, r, w, acc, lpc, dena;
        alu = (op >= 3'd2) && (op <= 3'd5);
        jmp = (op == 3'd7);
        sto = (op == 3'd6);
        skz = (op == 3'd1);
        inc = 0; ir = 0; r = 0; w = 0; acc = 0; lpc = 0; dena = 0;
        if (pos == 0 || pos == 1) begin
            inc = 1; ir = 1; r = 1;
        end else if (pos == 4) begin
            r = alu; lpc = jmp; dena = sto;
        end else if (pos == 5) begin
            r = alu; acc = alu; inc = (skz && z) || jmp; lpc = jmp; dena = sto; w = sto;
        end else if (pos == 6) begin
            dena = sto;
        end else if (pos == 7) begin
            inc = skz && z;
        end
        return {inc, ir, r, w, acc, lpc, dena, (pos == POS_HALT),
                (pos >= 0 && pos <= 7) ? 3'(pos) : 3'd0, (pos >= 0 && pos <= 7), s};
    endfunction

    // Reference model: instruction-cycle position as a plain integer.
    initial begin
        int  pos = POS_IDLE;
        int  nxt;
        bit  prev = 0, sync = 0, r;
        forever begin
            @(posedge clk);
            r = fetch && !prev;
            if (rst) begin
                pos = POS_IDLE; prev = 0; sync = 0;
                exp_q.push_back(13'd0);
            end else begin
                prev = fetch;
                if (pos == POS_HALT) nxt = POS_HALT;
                else if (pos == POS_IDLE) nxt = (r || START_ON_RESET) ? 0 : POS_IDLE;
                else if (pos == 3 && opcode == 3'd0) nxt = POS_HALT;
                else begin
                    nxt = (pos + 1) % 8;
`ifdef CTRL_SYNC_CHECK_EN
                    if (pos < 7 && r) begin nxt = 0; sync = 1; end
                    if (pos == 7 && !r) sync = 1;
`endif
                end
                pos = nxt;
                exp_q.push_back(expect_for(pos, opcode, zero, sync));
            end
        end
    end

    // Monitor: one transaction per clock, sampled 1 time unit after the edge.
    initial begin
        logic [12:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            got = {inc_pc, load_ir, rd, wr, load_acc, load_pc, datactl_ena, halt,
                   phase, running, sync_err};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty cyc=%0d got=%b required=an expectation", cycle, got);
            end else begin
                want = exp_q.pop_front();
                $display("cyc=%0d rst=%0b fetch=%0b op=%0d z=%0b exp=%b got=%b",
                         cycle, rst, fetch, opcode, zero, want, got);
                if (got !== want) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d got=%b required=%b", cycle, got, want);
                end
            end
            checks++;
            if ((rd && wr) || (load_pc && load_acc)) begin
                failures++;
                $display("FAIL exclusive_strobes cyc=%0d got rd=%0b wr=%0b load_pc=%0b load_acc=%0b required=not both",
                         cycle, rd, wr, load_pc, load_acc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (fetch_on) begin
            if (fcnt == 0) begin
                if (op_queue.size() != 0) opcode = op_queue.pop_front();
                else if (rand_op) opcode = 3'($urandom_range(1, 7));
            end
            fetch = (fcnt < 4);
            fcnt  = (fcnt + 1) % 8;
        end else begin
            fetch = 1'b0;
        end
        zero = 1'($urandom_range(0, 1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; fetch = 1'b0; opcode = 3'd2; zero = 1'b0;
        run(3);
        rst = 1'b0;
        run(4);                                 // idle with fetch low
        op_queue = '{3'd2, 3'd7, 3'd1, 3'd1, 3'd1, 3'd6, 3'd3, 3'd4, 3'd5};
        fetch_on = 1'b1; fcnt = 0;
        run(9 * 8);
        rand_op = 1'b1;
        run(30 * 8);
        while (fcnt != 5) step();               // stretch the low phase by 3 clocks
        fetch_on = 1'b0;
        run(3);
        fetch_on = 1'b1;
        run(6 * 8);
        while (fcnt != 0) step();
        op_queue.push_back(3'd0);               // HLT
        run(30);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        fetch_on = 1'b0;
        run(6);
        fetch_on = 1'b1; fcnt = 0;
        run(3 * 8 + 3);
        rst = 1'b1;                             // abort a cycle mid-way
        run(1);
        rst = 1'b0;
        run(4 * 8);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
